// File: rtl/alu_operand_fifo_pkg.sv
// Shared ALU definitions: operand-tuple word layout used between producer, buffer and adder.
// Word layout is {c_in, add_2, add_1}, with add_1 in the low bits.
package alu_operand_fifo_pkg;

    localparam int ALU_DATA_SIZE = 8;
    localparam int ADD_1_LSB     = 0;

    function automatic int entry_w(input int data_size);
        return 2 * data_size + 1;
    endfunction

    function automatic int add_2_lsb(input int data_size);
        return data_size;
    endfunction

    function automatic int c_in_bit(input int data_size);
        return 2 * data_size;
    endfunction

endpackage

// File: rtl/d_ff_async_en.sv
// Enabled register bank with asynchronous active-high reset to a parameterised value.
module d_ff_async_en #(
    parameter int              SIZE        = 1,
    parameter logic [SIZE-1:0] RESET_VALUE = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [SIZE-1:0] d_i,
    output logic [SIZE-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= RESET_VALUE;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/alu_operand_fifo.sv
// Operand-tuple FIFO feeding the adder. The head entry falls through combinationally;
// a push is visible one cycle later, and a full FIFO refuses writes even while popping.
module alu_operand_fifo
    import alu_operand_fifo_pkg::*;
#(
    parameter  int DATA_SIZE = ALU_DATA_SIZE,
    parameter  int DEPTH     = 4,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_SIZE-1:0] wr_add_1,
    input  logic [DATA_SIZE-1:0] wr_add_2,
    input  logic                 wr_c_in,
    output logic                 a_valid_f_data,
    input  logic                 a_ready_f_data,
    output logic [DATA_SIZE-1:0] add_1,
    output logic [DATA_SIZE-1:0] add_2,
    output logic                 c_in,
    output logic [ADDR_W:0]      count
);

    localparam int              W         = entry_w(DATA_SIZE);
    localparam int              ADD_2_LSB = add_2_lsb(DATA_SIZE);
    localparam int              C_IN_BIT  = c_in_bit(DATA_SIZE);
    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [W-1:0]      mem_q [DEPTH];
    logic [W-1:0]      wr_word;
    logic [W-1:0]      head_word;
    logic              push, pop;

    // Strict valid/ready: a transfer happens only on a cycle where both are high.
    assign wr_ready       = (count_q != FULL_CNT);
    assign a_valid_f_data = (count_q != '0);
    assign push           = wr_valid & wr_ready;
    assign pop            = a_valid_f_data & a_ready_f_data;

    assign wr_word  = {wr_c_in, wr_add_2, wr_add_1};
    assign wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    assign rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    d_ff_async_en #(.SIZE(ADDR_W), .RESET_VALUE('0)) u_wr_ptr (
        .clk_i(clk), .rst_i(rst), .en_i(push), .d_i(wr_ptr_d), .q_o(wr_ptr_q)
    );

    d_ff_async_en #(.SIZE(ADDR_W), .RESET_VALUE('0)) u_rd_ptr (
        .clk_i(clk), .rst_i(rst), .en_i(pop), .d_i(rd_ptr_d), .q_o(rd_ptr_q)
    );

    d_ff_async_en #(.SIZE(ADDR_W + 1), .RESET_VALUE('0)) u_count (
        .clk_i(clk), .rst_i(rst), .en_i(push | pop), .d_i(count_d), .q_o(count_q)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_mem
        d_ff_async_en #(.SIZE(W), .RESET_VALUE('0)) u_entry (
            .clk_i(clk),
            .rst_i(rst),
            .en_i (push & (wr_ptr_q == ADDR_W'(i))),
            .d_i  (wr_word),
            .q_o  (mem_q[i])
        );
    end

    // Memory resets to zero, so the head is deterministic even when empty.
    assign head_word = mem_q[rd_ptr_q];
    assign add_1     = head_word[ADD_1_LSB +: DATA_SIZE];
    assign add_2     = head_word[ADD_2_LSB +: DATA_SIZE];
    assign c_in      = head_word[C_IN_BIT];
    assign count     = count_q;

endmodule

// File: tb/tb_alu_operand_fifo.sv
// Bench for alu_operand_fifo: directed and random tuples checked against a queue model.
module tb_alu_operand_fifo;

    localparam int DS    = 8;
    localparam int DEPTH = 4;
    localparam int W     = 2 * DS + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DS-1:0] wr_add_1 = '0;
    logic [DS-1:0] wr_add_2 = '0;
    logic          wr_c_in = 1'b0;
    logic          a_valid_f_data;
    logic          a_ready_f_data = 1'b0;
    logic [DS-1:0] add_1;
    logic [DS-1:0] add_2;
    logic          c_in;
    logic [2:0]    count;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;

    alu_operand_fifo #(.DATA_SIZE(DS), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_add_1      (wr_add_1),
        .wr_add_2      (wr_add_2),
        .wr_c_in       (wr_c_in),
        .a_valid_f_data(a_valid_f_data),
        .a_ready_f_data(a_ready_f_data),
        .add_1         (add_1),
        .add_2         (add_2),
        .c_in          (c_in),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare flags, occupancy and head against the queue model.
    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'(exp_q.size()));
        check({tag, ".wr_ready"}, 32'(wr_ready), 32'(exp_q.size() < DEPTH));
        check({tag, ".a_valid"}, 32'(a_valid_f_data), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check({tag, ".head"}, 32'({c_in, add_2, add_1}), 32'(exp_q[0]));
        end
    endtask

    // One clock: drive at negedge, check just after, model the edge.
    task automatic step(input string tag, input bit wv, input logic [DS-1:0] a1,
                        input logic [DS-1:0] a2, input bit ci, input bit ar);
        bit do_push, do_pop;
        @(negedge clk);
        wr_valid       = wv;
        wr_add_1       = a1;
        wr_add_2       = a2;
        wr_c_in        = ci;
        a_ready_f_data = ar;
        #1;
        check_state(tag);
        do_push = wv && (exp_q.size() < DEPTH);
        do_pop  = ar && (exp_q.size() > 0);
        @(posedge clk);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({ci, a2, a1});
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".a_valid"}, 32'(a_valid_f_data), 32'd0);
        check({tag, ".wr_ready"}, 32'(wr_ready), 32'd1);
        check({tag, ".count"}, 32'(count), 32'd0);
        check({tag, ".head"}, 32'({c_in, add_2, add_1}), 32'd0);
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_cleared("reset");
        step("idle", 0, 8'h00, 8'h00, 0, 0);

        // Single push into empty FIFO, then drain
        step("push1", 1, 8'h12, 8'h34, 1, 0);
        step("see1", 0, 8'h00, 8'h00, 0, 0);
        step("drain1", 0, 8'h00, 8'h00, 0, 1);

        // Fill to DEPTH, refused 5th push, pop-only while full, then accepted push
        for (int i = 1; i <= 4; i++) step("fill", 1, 8'(i), 8'(i + 8'h40), 0, 0);
        step("full_refuse", 1, 8'h05, 8'h45, 1, 0);
        step("full_pop", 1, 8'h05, 8'h45, 1, 1);
        step("push5", 1, 8'h05, 8'h45, 1, 0);
        for (int i = 0; i < 5; i++) step("drain5", 0, 8'h00, 8'h00, 0, 1);
        step("empty5", 0, 8'h00, 8'h00, 0, 0);

        // Two preloaded, then simultaneous push/pop across the pointer wrap
        step("pre_a", 1, 8'h20, 8'h21, 0, 0);
        step("pre_b", 1, 8'h22, 8'h23, 1, 0);
        for (int i = 0; i < 10; i++) step("stream", 1, 8'(8'h10 + i), 8'(8'h80 + i), i[0], 1);
        for (int i = 0; i < 3; i++) step("drain_s", 0, 8'h00, 8'h00, 0, 1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        while (exp_q.size() > 0) step("drain_r", 0, 8'h00, 8'h00, 0, 1);

        // Asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 8'(8'h60 + i), 8'h99, 1, 0);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_add_1 = 8'h6f;
        a_ready_f_data = 1'b1;
        rst = 1'b1;
        #1;
        check_cleared("async_rst");
        exp_q.delete();
        @(negedge clk);
        wr_valid = 1'b0;
        a_ready_f_data = 1'b0;
        rst = 1'b0;
        #1;
        check_cleared("post_rst");
        step("push_after", 1, 8'h77, 8'h88, 1, 0);
        step("see_after", 0, 8'h00, 8'h00, 0, 0);
        step("drain_after", 0, 8'h00, 8'h00, 0, 1);
        step("final", 0, 8'h00, 8'h00, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_fifo.md
# alu_operand_fifo

Operand buffer on the data side of the ALU. It accepts operand tuples {add_1, add_2, c_in} from an upstream producer. It stores up to DEPTH of them and presents them in order to the adder through the a_valid_f_data / a_ready_f_data handshake, acting as the transmitting end of that interface. It decouples producer bursts from adder back-pressure.

## Interface
- DATA_SIZE, 8, width of each addend
- DEPTH, 4, number of tuple entries; power of two, ≥2
- ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  producer has a tuple
- wr_ready  out  1  FIFO can accept a tuple this cycle
- wr_add_1  in  DATA_SIZE  operand 1
- wr_add_2  in  DATA_SIZE  operand 2
- wr_c_in  in  1  carry-in
- a_valid_f_data  out  1  head tuple valid toward adder
- a_ready_f_data  in  1  adder accepts head tuple
- add_1  out  DATA_SIZE  head operand 1
- add_2  out  DATA_SIZE  head operand 2
- c_in  out  1  head carry-in
- count  out  ADDR_W+1  occupied entries, 0..DEPTH

## Operation
- Entry word is {c_in, add_2, add_1}, W = 2*DATA_SIZE+1 bits.
- push = wr_valid & wr_ready. On push, the word is written at wr_ptr and wr_ptr increments.
- pop = a_valid_f_data & a_ready_f_data. On pop, rd_ptr increments.
- Pointers are ADDR_W bits and wrap modulo DEPTH.
- count register:
  - +1 on push only
  - −1 on pop only
  - unchanged on push and pop together, or on neither
- wr_ready = (count != DEPTH), combinational from the register.
- a_valid_f_data = (count != 0), combinational from the register.
- Head outputs are first-word-fall-through: {c_in, add_2, add_1} = mem[rd_ptr], combinational read. They are don't-care while a_valid_f_data = 0, but are deterministic because the memory resets to 0.
- Full: wr_ready = 0 even if a pop happens the same cycle. There is no push-through when full.
- Empty: a push makes the tuple visible on the next cycle. A push into an empty FIFO never bypasses to the outputs in the same cycle.
- Producer contract: hold wr_* stable while wr_valid = 1 and wr_ready = 0. The FIFO does not check this.
- Adder contract: head data stays stable until it is popped.

## Timing
- Reset (asynchronous assert, synchronous release to the next edge):
  - wr_ptr = rd_ptr = 0, count = 0, all mem = 0
  - a_valid_f_data = 0, wr_ready = 1
  - add_1 = add_2 = 0, c_in = 0
- Latency is 1 cycle from a push edge to a_valid_f_data = 1 when the FIFO was empty.
- Throughput is 1 tuple/cycle when neither full nor empty, with simultaneous push and pop.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock. Any handshake in flight that cycle is void.
- Wrap: after DEPTH pushes, wr_ptr returns to 0; ordering is preserved across the wrap.

## Structure
- Shared ALU package holds:
  - the entry-word width constant W = 2*DATA_SIZE+1
  - field offsets for c_in, add_2 and add_1 inside the word
- Storage is DEPTH instances of d_ff_async_en (SIZE = W, RESET_VALUE = 0, en = push & (wr_ptr == i), rst = rst).
- Pointers and count are d_ff_async_en instances enabled on push, pop, or either.
- The only sub-module is d_ff_async_en. Read mux and flag logic are inline.

## Test plan
- Reset, then idle → count = 0, a_valid_f_data = 0, wr_ready = 1, add_1 = 0.
- Push {add_1 = 8'h12, add_2 = 8'h34, c_in = 1} into empty FIFO with a_ready_f_data = 0 → next cycle a_valid_f_data = 1, head = 12/34/1, count = 1.
- Push 4 tuples (0x01..0x04), a_ready_f_data held 0 → wr_ready = 0 after the 4th, count = 4. A 5th push attempt (0x05) is not accepted.
- Full FIFO with wr_valid = 1 and a_ready_f_data = 1 for one cycle → pop only, count = 3, then a push next cycle. Output order is 0x01, 0x02, 0x03, 0x04, 0x05.
- Continuous push and pop for 10 cycles (values 0x10..0x19) with 2 preloaded → count stays 2. Pointers wrap, output order is preserved, and no tuple is dropped or duplicated.
- Assert rst mid-stream with count = 3 → within the same cycle a_valid_f_data = 0, count = 0, outputs = 0. After release, the first push appears alone at the head.
